// File: rtl/iram_controller.sv
// Instruction-cache refill controller: on a miss, fetches one aligned line
// from IRAM and streams the words back to the fetch unit in order.
module iram_controller #(
   parameter int PC_SIZE    = 32,
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          miss_cache,
   input  logic [PC_SIZE-1:0]            ram_address,
   output logic [WORD_W-1:0]             mem_word,
   output logic                          word_ready,
   output logic [$clog2(LINE_WORDS)-1:0] word_offset,
   output logic                          refill_done,
   output logic                          busy,
   output logic                          ram_rd_en,
   output logic [PC_SIZE-1:0]            ram_rd_addr,
   input  logic                          ram_rdy,
   input  logic [WORD_W-1:0]             ram_rd_data,
   input  logic                          ram_rd_valid
);

   localparam int OW = $clog2(LINE_WORDS);
   localparam int CW = OW + 1;
   localparam logic [CW-1:0]      LAST      = CW'(LINE_WORDS);
   localparam logic [PC_SIZE-1:0] LINE_MASK = PC_SIZE'(LINE_WORDS * 4 - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t             state;
   logic [PC_SIZE-1:0] base;
   logic [CW-1:0]      req_cnt;
   logic [CW-1:0]      rsp_cnt;
   logic [CW-1:0]      req_nxt;
   logic [PC_SIZE-1:0] miss_base;
   logic               fire;
   logic               rsp_ok;

   assign req_nxt   = req_cnt + 1'b1;
   assign miss_base = ram_address & ~LINE_MASK;
   assign fire      = ram_rd_en & ram_rdy;
   // Responses only count while a refill is in flight and the line is not yet full.
   assign rsp_ok    = ram_rd_valid && (state == ISSUE || state == DRAIN) && (rsp_cnt < LAST);

   // Refill FSM, request/response counters and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         base        <= '0;
         req_cnt     <= '0;
         rsp_cnt     <= '0;
         mem_word    <= '0;
         word_ready  <= 1'b0;
         word_offset <= '0;
         refill_done <= 1'b0;
         busy        <= 1'b0;
         ram_rd_en   <= 1'b0;
         ram_rd_addr <= '0;
      end else begin
         word_ready  <= 1'b0;
         refill_done <= 1'b0;
         case (state)
            IDLE: begin
               if (miss_cache) begin
                  base        <= miss_base;
                  req_cnt     <= '0;
                  rsp_cnt     <= '0;
                  ram_rd_en   <= 1'b1;
                  ram_rd_addr <= miss_base;
                  busy        <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (fire) begin
                  req_cnt <= req_nxt;
                  if (req_nxt == LAST) begin
                     ram_rd_en <= 1'b0;
                     state     <= DRAIN;
                  end else begin
                     ram_rd_addr <= base + (PC_SIZE'(req_nxt) << 2);
                  end
               end
            end
            DRAIN: begin
               if (rsp_cnt == LAST) begin
                  refill_done <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (rsp_ok) begin
            mem_word    <= ram_rd_data;
            word_offset <= rsp_cnt[OW-1:0];
            word_ready  <= 1'b1;
            rsp_cnt     <= rsp_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_iram_controller.sv
// Bench for iram_controller: an IRAM model with configurable latency and
// ready pattern, plus scoreboards for request addresses and returned words.
module tb_iram_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        miss_cache = 1'b0;
   logic [31:0] ram_address = '0;
   logic [31:0] mem_word;
   logic        word_ready;
   logic [1:0]  word_offset;
   logic        refill_done;
   logic        busy;
   logic        ram_rd_en;
   logic [31:0] ram_rd_addr;
   logic        ram_rdy = 1'b0;
   logic [31:0] ram_rd_data = '0;
   logic        ram_rd_valid = 1'b0;

   iram_controller #(.PC_SIZE(32), .WORD_W(32), .LINE_WORDS(4)) dut (
      .clk(clk), .rst(rst), .miss_cache(miss_cache), .ram_address(ram_address),
      .mem_word(mem_word), .word_ready(word_ready), .word_offset(word_offset),
      .refill_done(refill_done), .busy(busy), .ram_rd_en(ram_rd_en),
      .ram_rd_addr(ram_rd_addr), .ram_rdy(ram_rdy), .ram_rd_data(ram_rd_data),
      .ram_rd_valid(ram_rd_valid)
   );

   always #5 clk = ~clk;

   typedef struct { int due; logic [31:0] data; bit exp; } rsp_t;
   typedef struct { int cyc; logic [31:0] data; logic [1:0] off; } exp_t;

   rsp_t        pend[$];
   exp_t        expq[$];
   logic [31:0] addrq[$];
   int          fire_cyc[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int lat = 1;
   int rdy_mode = 0;
   int rdy_ph = 0;
   int offs = 0;
   int done_cyc = -1;
   int dones = 0;
   bit spur = 0;

   // IRAM model and scoreboard, evaluated on the falling edge.
   always @(negedge clk) begin
      rsp_t r;
      exp_t e;
      logic rdy;
      cyc = cyc + 1;
      if (expq.size() != 0 && expq[0].cyc == cyc) begin
         e = expq.pop_front();
         checks++;
         if (word_ready !== 1'b1 || mem_word !== e.data || word_offset !== e.off) begin
            failures++;
            $display("FAIL word cyc=%0d got rdy=%b data=%h off=%0d want data=%h off=%0d",
                     cyc, word_ready, mem_word, word_offset, e.data, e.off);
         end
      end else if (word_ready !== 1'b0) begin
         checks++; failures++;
         $display("FAIL unexpected_word cyc=%0d got word_ready=%b want 0", cyc, word_ready);
      end
      if (refill_done === 1'b1) dones++;
      if (cyc == done_cyc || refill_done !== 1'b0) begin
         checks++;
         if (refill_done !== (cyc == done_cyc)) begin
            failures++;
            $display("FAIL refill_done cyc=%0d got %b want %b", cyc, refill_done, cyc == done_cyc);
         end
      end
      if (pend.size() != 0 && pend[0].due <= cyc) begin
         r = pend.pop_front();
         ram_rd_valid = 1'b1;
         ram_rd_data  = r.data;
         if (r.exp) begin
            e.cyc = cyc + 1; e.data = r.data; e.off = 2'(offs);
            expq.push_back(e);
            if (offs == 3) done_cyc = cyc + 2;
            offs = (offs + 1) % 4;
         end
      end else if (spur) begin
         spur = 0;
         ram_rd_valid = 1'b1;
         ram_rd_data  = $urandom;
      end else begin
         ram_rd_valid = 1'b0;
         ram_rd_data  = $urandom;
      end
      rdy = (rdy_mode == 0) ? 1'b1 : ((rdy_ph % 3) == 0);
      rdy_ph++;
      ram_rdy = rdy;
      if (ram_rd_en === 1'b1 && rdy) begin
         checks++;
         fire_cyc.push_back(cyc);
         if (addrq.size() == 0) begin
            failures++;
            $display("FAIL extra_request cyc=%0d got addr=%h want no request", cyc, ram_rd_addr);
         end else if (ram_rd_addr !== addrq[0]) begin
            failures++;
            $display("FAIL req_addr cyc=%0d got %h want %h", cyc, ram_rd_addr, addrq[0]);
            void'(addrq.pop_front());
         end else begin
            void'(addrq.pop_front());
         end
         r.due = cyc + lat; r.data = $urandom; r.exp = 1;
         pend.push_back(r);
      end
   end

   // Queue the four expected request addresses for a miss at addr.
   task automatic push_line(input logic [31:0] addr);
      logic [31:0] b;
      b = addr & 32'hFFFF_FFF0;
      for (int k = 0; k < 4; k++) addrq.push_back(b + 32'(4 * k));
   endtask

   task automatic start_miss(input logic [31:0] addr, output int c);
      @(negedge clk); #1;
      push_line(addr);
      fire_cyc.delete();
      miss_cache  = 1'b1;
      ram_address = addr;
      c = cyc;
   endtask

   // Wait for refill_done, counting cycles with busy low along the way.
   task automatic wait_done(input string name, output int dcyc, output int busy_low);
      dcyc = -1; busy_low = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (busy !== 1'b1) busy_low++;
         if (refill_done === 1'b1) begin dcyc = cyc; break; end
      end
      checks++;
      if (dcyc < 0) begin
         failures++;
         $display("FAIL %s_timeout got no refill_done want refill_done within 200 cycles", name);
      end
   endtask

   task automatic check_drained(input string name);
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (addrq.size() != 0 || expq.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_drained got addrq=%0d expq=%0d busy=%b want 0 0 0",
                  name, addrq.size(), expq.size(), busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({word_ready, refill_done, busy, ram_rd_en} !== 4'b0 || ram_rd_addr !== 32'h0 ||
          mem_word !== 32'h0 || word_offset !== 2'd0) begin
         failures++;
         $display("FAIL reset_outputs got rdy=%b done=%b busy=%b en=%b addr=%h word=%h want all 0",
                  word_ready, refill_done, busy, ram_rd_en, ram_rd_addr, mem_word);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      int c, d, bl, d0;
      lat = 1; rdy_mode = 0;
      d0 = dones;
      start_miss(32'h0000_104C, c);
      wait_done("basic", d, bl);
      miss_cache = 1'b0;
      checks++;
      if (fire_cyc.size() != 4 || fire_cyc[0] != c + 1 || fire_cyc[3] != c + 4) begin
         failures++;
         $display("FAIL basic_fire_timing got n=%0d first=%0d want n=4 first=%0d last=%0d",
                  fire_cyc.size(), fire_cyc.size() ? fire_cyc[0] : -1, c + 1, c + 4);
      end
      checks++;
      if (bl != 0) begin
         failures++;
         $display("FAIL basic_busy got %0d low cycles want 0", bl);
      end
      check_drained("basic");
      checks++;
      if (dones - d0 != 1) begin
         failures++;
         $display("FAIL basic_done_count got %0d want 1", dones - d0);
      end
   endtask

   task automatic test_stall();
      int c, d, bl, d0;
      lat = 3; rdy_mode = 1; rdy_ph = 0;
      d0 = dones;
      start_miss(32'h0000_104C, c);
      wait_done("stall", d, bl);
      miss_cache = 1'b0;
      checks++;
      if (fire_cyc.size() != 4) begin
         failures++;
         $display("FAIL stall_fires got %0d want 4", fire_cyc.size());
      end
      check_drained("stall");
      checks++;
      if (dones - d0 != 1) begin
         failures++;
         $display("FAIL stall_done_count got %0d want 1", dones - d0);
      end
      rdy_mode = 0;
   endtask

   task automatic test_drop_miss();
      int c, d, bl;
      lat = 2;
      start_miss(32'h0000_2000, c);
      @(negedge clk); #1;
      miss_cache = 1'b0;
      wait_done("drop", d, bl);
      check_drained("drop");
   endtask

   task automatic test_wrap();
      int c, d, bl;
      lat = 1;
      start_miss(32'hFFFF_FFF8, c);
      wait_done("wrap", d, bl);
      miss_cache = 1'b0;
      check_drained("wrap");
   endtask

   task automatic test_reset_mid();
      int c, d, bl, got;
      lat = 3;
      start_miss(32'h0000_3010, c);
      @(negedge clk); #1;
      miss_cache = 1'b0;
      got = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (word_ready === 1'b1 && word_offset === 2'd1) begin got = 1; break; end
      end
      checks++;
      if (got == 0) begin
         failures++;
         $display("FAIL rstmid_second_word got none want word_offset=1");
      end
      rst = 1'b1;
      foreach (pend[i]) pend[i].exp = 0;
      expq.delete(); addrq.delete();
      done_cyc = -1; offs = 0;
      #1;
      checks++;
      if ({word_ready, refill_done, busy, ram_rd_en} !== 4'b0 || ram_rd_addr !== 32'h0) begin
         failures++;
         $display("FAIL rstmid_async got rdy=%b done=%b busy=%b en=%b addr=%h want all 0",
                  word_ready, refill_done, busy, ram_rd_en, ram_rd_addr);
      end
      checks++;
      if (pend.size() != 2) begin
         failures++;
         $display("FAIL rstmid_inflight got %0d want 2", pend.size());
      end
      @(negedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 20 && pend.size() != 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      start_miss(32'h0000_3010, c);
      wait_done("rstmid_new", d, bl);
      miss_cache = 1'b0;
      checks++;
      if (fire_cyc.size() != 4) begin
         failures++;
         $display("FAIL rstmid_new_fires got %0d want 4", fire_cyc.size());
      end
      check_drained("rstmid");
   endtask

   task automatic test_back_to_back();
      int c, d, bl, sp;
      lat = 1;
      @(negedge clk); #1;
      spur = 1;
      sp = 0;
      repeat (4) begin
         @(negedge clk); #1;
         if (word_ready !== 1'b0) sp++;
      end
      checks++;
      if (sp != 0) begin
         failures++;
         $display("FAIL spurious_idle got %0d word_ready want 0", sp);
      end
      start_miss(32'h0000_5004, c);
      push_line(32'h0000_5004);
      wait_done("b2b_first", d, bl);
      for (int i = 0; i < 10 && fire_cyc.size() < 5; i++) @(negedge clk);
      #1;
      miss_cache = 1'b0;
      checks++;
      if (fire_cyc.size() < 5 || fire_cyc[4] != d + 2) begin
         failures++;
         $display("FAIL b2b_restart got %0d want %0d", fire_cyc.size() >= 5 ? fire_cyc[4] : -1, d + 2);
      end
      wait_done("b2b_second", d, bl);
      check_drained("b2b");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_drop_miss();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iram_controller.md
Name: iram_controller

Overview:
- Services instruction-cache misses from the core's fetch unit.
- On `miss_cache`, it captures `ram_address`, aligns it to the cache-line base, and issues `LINE_WORDS` sequential read requests to instruction RAM.
- It returns each word to the core in order with a one-cycle `word_ready` pulse, then signals end of refill.
- Sits between the fetch unit (upstream consumer) and the IRAM macro.

Parameters:
- PC_SIZE, 32, byte-address width (matches core pc_size)
- WORD_W, 32, memory word width (matches core memory_word)
- LINE_WORDS, 4, words per cache line; power of two, >= 2

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- miss_cache  in  1  core requests a line refill (level)
- ram_address  in  PC_SIZE  byte address of the missed fetch, valid with miss_cache
- mem_word  out  WORD_W  word returned to the core
- word_ready  out  1  mem_word valid this cycle (one-cycle pulse per word)
- word_offset  out  log2(LINE_WORDS)  index of mem_word within the line
- refill_done  out  1  one-cycle pulse after the last word
- busy  out  1  high in every non-IDLE state
- ram_rd_en  out  1  read request to IRAM
- ram_rd_addr  out  PC_SIZE  byte address of the request
- ram_rdy  in  1  IRAM accepts the request this cycle (request fires when ram_rd_en && ram_rdy)
- ram_rd_data  in  WORD_W  read data
- ram_rd_valid  in  1  ram_rd_data valid; responses return in request order, arbitrary latency >= 1

Behaviour:
- Reset: the clock is `clk` and the reset is `rst`, asynchronous and active-high. Assertion at any time, including mid-refill, forces IDLE, clears both counters and drives all outputs to 0. Responses still in flight after reset are ignored.
- All outputs are registered.
- Line base: ram_address with the low log2(LINE_WORDS)+2 bits cleared. Request k uses address base + 4*k. Computation is modulo 2^PC_SIZE.
- Counters:
  - req_cnt and rsp_cnt, each 0..LINE_WORDS.
  - req_cnt increments on each fired request.
  - rsp_cnt increments on each accepted ram_rd_valid.
- State IDLE: busy=0, ram_rd_en=0.
  - miss_cache=1 sampled at edge t latches the base, clears both counters and moves to ISSUE.
  - ram_rd_en=1 with ram_rd_addr=base from cycle t+1.
- State ISSUE:
  - ram_rd_en=1 and ram_rd_addr=base+4*req_cnt.
  - Holds the address stable while ram_rdy=0.
  - When the fire brings req_cnt to LINE_WORDS, ram_rd_en drops the following cycle and the state moves to DRAIN.
  - Back-to-back fires (ram_rdy=1 every cycle) give one request per cycle.
- State DRAIN: ram_rd_en=0; waits for the remaining responses.
- Responses in ISSUE or DRAIN: ram_rd_valid at edge n gives, at n+1:
  - mem_word = ram_rd_data
  - word_offset = rsp_cnt
  - word_ready = 1
- Responses may overlap with issuing: one fire and one response in the same cycle are both counted.
- When rsp_cnt reaches LINE_WORDS, the state moves to DONE.
- State DONE: refill_done=1 for exactly one cycle, coincident with the cycle after the last word_ready. miss_cache is ignored in DONE. The state then returns to IDLE, where a still-asserted miss_cache starts a new refill.
- Data hold: mem_word holds its last value between pulses; only word_ready qualifies it.
- miss_cache deasserted mid-refill: the refill completes anyway, so a line is never left partially filled.
- ram_address changes during a refill are ignored.
- ram_rd_valid in IDLE or DONE, or beyond LINE_WORDS responses, is ignored (counter saturates) and produces no word_ready.
- The controller has no backpressure from the core; the fetch unit must accept every word_ready.

Test Plan:
- Reset, then miss_cache=1 with ram_address=0x0000_104C, ram_rdy=1, latency 1 -> ram_rd_addr = 0x1040, 0x1044, 0x1048, 0x104C on consecutive cycles. Four word_ready pulses follow with word_offset 0..3 and data matching. refill_done fires one cycle after the last word; busy=1 throughout.
- Same miss with ram_rdy toggling 1,0,0,1,... and latency 3 -> address held while ram_rdy=0, exactly 4 requests fired, responses in order, one refill_done.
- miss_cache dropped the cycle after acceptance -> all 4 words still delivered, then refill_done.
- Wrap-around: ram_address=0xFFFF_FFF8 -> requests 0xFFFF_FFF0, 0xFFFF_FFF4, 0xFFFF_FFF8, 0xFFFF_FFFC; no carry into extra bits.
- rst pulsed after 2 responses, with 2 responses still in flight -> outputs 0 immediately (asynchronous). The late responses produce no word_ready; a new miss fetches a full fresh line.
- Spurious ram_rd_valid in IDLE, and miss_cache held through DONE -> no word_ready from the spurious valid. The second refill's first request appears exactly 2 cycles after refill_done.
